// File: rtl/hub75_bcm_player.sv
// hub75_bcm_player -- HUB75 panel scanner with BCM bit planes and animated frame sequencing.
// Rev 1.0
`default_nettype none

module hub75_bcm_player #(
    parameter int PANEL_W    = 32,
    parameter int SCAN_ROWS  = 16,
    parameter int COLOR_BITS = 4,
    parameter int NUM_FRAMES = 60,
    parameter int FRAME_HOLD = 64,
    parameter int BASE_SHOW  = 64,
    parameter int ADDR_W     = 16
) (
    input  logic                                                clk,
    input  logic                                                reset_n,
    input  logic                                                pause,
    output logic [ADDR_W-1:0]                                   mem_addr_top,
    output logic [ADDR_W-1:0]                                   mem_addr_bot,
    input  logic [3*COLOR_BITS-1:0]                             mem_dout_top,
    input  logic [3*COLOR_BITS-1:0]                             mem_dout_bot,
    output logic                                                r1,
    output logic                                                g1,
    output logic                                                b1,
    output logic                                                r2,
    output logic                                                g2,
    output logic                                                b2,
    output logic [$clog2(SCAN_ROWS)-1:0]                        row_addr,
    output logic                                                clk_out,
    output logic                                                lat,
    output logic                                                oe,
    output logic [((NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1)-1:0] frame_idx,
    output logic                                                frame_tick
);

    localparam int COL_W   = $clog2(PANEL_W);
    localparam int ROW_W   = $clog2(SCAN_ROWS);
    localparam int PLANE_W = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
    localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int HOLD_W  = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam int SHOW_W  = $clog2((BASE_SHOW << (COLOR_BITS - 1)) + 1);
    localparam int CB      = COLOR_BITS;

    typedef enum logic [1:0] {FETCH, SHIFT, LATCH, SHOW} state_t;

    state_t              state;
    logic                phase;
    logic [COL_W-1:0]    col;
    logic [ROW_W-1:0]    row;
    logic [PLANE_W-1:0]  plane;
    logic [HOLD_W-1:0]   hold;
    logic [SHOW_W-1:0]   show_cnt;
    logic [SHOW_W-1:0]   show_len;
    logic [2:0]          top_bits;
    logic [2:0]          bot_bits;
    logic [2:0]          top_sel;
    logic [2:0]          bot_sel;
    logic                shift_ph0;
    logic [ADDR_W-1:0]   frame_base;
    logic [ADDR_W-1:0]   col_off;
    logic [CB-1:0]       top_r, top_g, top_b, bot_r, bot_g, bot_b;

    // Addresses are decoded from registered state so FETCH always sees the row/plane/frame just committed.
    assign frame_base   = ADDR_W'(frame_idx) * ADDR_W'(PANEL_W * 2 * SCAN_ROWS);
    assign col_off      = (state == SHIFT) ? (ADDR_W'(col) + ADDR_W'(1)) : '0;
    assign mem_addr_top = frame_base + ADDR_W'(row) * ADDR_W'(PANEL_W) + col_off;
    assign mem_addr_bot = mem_addr_top + ADDR_W'(SCAN_ROWS * PANEL_W);

    assign top_r = mem_dout_top[3*CB-1:2*CB];
    assign top_g = mem_dout_top[2*CB-1:CB];
    assign top_b = mem_dout_top[CB-1:0];
    assign bot_r = mem_dout_bot[3*CB-1:2*CB];
    assign bot_g = mem_dout_bot[2*CB-1:CB];
    assign bot_b = mem_dout_bot[CB-1:0];

    assign top_sel   = {top_r[plane], top_g[plane], top_b[plane]};
    assign bot_sel   = {bot_r[plane], bot_g[plane], bot_b[plane]};
    assign shift_ph0 = (state == SHIFT) && !phase;

    // Colour pins follow memory data in phase 0 so they settle a full clock before clk_out rises.
    assign {r1, g1, b1} = shift_ph0 ? top_sel : top_bits;
    assign {r2, g2, b2} = shift_ph0 ? bot_sel : bot_bits;

    assign show_len = SHOW_W'(BASE_SHOW) << plane;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= FETCH;
            phase      <= 1'b0;
            col        <= '0;
            row        <= '0;
            plane      <= '0;
            hold       <= '0;
            show_cnt   <= '0;
            frame_idx  <= '0;
            row_addr   <= '0;
            top_bits   <= '0;
            bot_bits   <= '0;
            clk_out    <= 1'b0;
            lat        <= 1'b0;
            oe         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            case (state)
                FETCH: begin
                    state <= SHIFT;
                    phase <= 1'b0;
                end
                SHIFT: begin
                    if (!phase) begin
                        top_bits <= top_sel;
                        bot_bits <= bot_sel;
                        clk_out  <= 1'b1;
                        phase    <= 1'b1;
                    end else begin
                        clk_out <= 1'b0;
                        phase   <= 1'b0;
                        if (col == COL_W'(PANEL_W - 1)) begin
                            col      <= '0;
                            lat      <= 1'b1;
                            row_addr <= row;
                            state    <= LATCH;
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end
                LATCH: begin
                    lat      <= 1'b0;
                    oe       <= 1'b0;
                    show_cnt <= '0;
                    state    <= SHOW;
                end
                SHOW: begin
                    if (show_cnt == show_len - SHOW_W'(1)) begin
                        oe    <= 1'b1;
                        state <= FETCH;
                        if (plane != PLANE_W'(COLOR_BITS - 1)) begin
                            plane <= plane + PLANE_W'(1);
                        end else begin
                            plane <= '0;
                            if (row != ROW_W'(SCAN_ROWS - 1)) begin
                                row <= row + ROW_W'(1);
                            end else begin
                                // End of a full panel refresh: frame sequencing happens only here.
                                row        <= '0;
                                frame_tick <= 1'b1;
                                if (pause) begin
                                    hold <= '0;
                                end else if (hold == HOLD_W'(FRAME_HOLD - 1)) begin
                                    hold <= '0;
                                    if (frame_idx == FRAME_W'(NUM_FRAMES - 1))
                                        frame_idx <= '0;
                                    else
                                        frame_idx <= frame_idx + FRAME_W'(1);
                                end else begin
                                    hold <= hold + HOLD_W'(1);
                                end
                            end
                        end
                    end else begin
                        show_cnt <= show_cnt + SHOW_W'(1);
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hub75_bcm_player.sv
// tb_hub75_bcm_player -- directed bench for hub75_bcm_player on a 4x4 panel, 2-bit colour.
// Rev 1.0
`default_nettype none

module tb_hub75_bcm_player;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pause;
    logic [15:0] mem_addr_top, mem_addr_bot;
    logic [5:0]  mem_dout_top, mem_dout_bot;
    logic        r1, g1, b1, r2, g2, b2;
    logic [0:0]  row_addr;
    logic        clk_out, lat, oe;
    logic [1:0]  frame_idx;
    logic        frame_tick;

    int checks;
    int failures;

    hub75_bcm_player #(
        .PANEL_W(4), .SCAN_ROWS(2), .COLOR_BITS(2), .NUM_FRAMES(3),
        .FRAME_HOLD(2), .BASE_SHOW(3), .ADDR_W(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pause(pause),
        .mem_addr_top(mem_addr_top), .mem_addr_bot(mem_addr_bot),
        .mem_dout_top(mem_dout_top), .mem_dout_bot(mem_dout_bot),
        .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
        .row_addr(row_addr), .clk_out(clk_out), .lat(lat), .oe(oe),
        .frame_idx(frame_idx), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Synchronous memory: pixel value is the low six address bits.
    always @(posedge clk) begin
        mem_dout_top <= mem_addr_top[5:0];
        mem_dout_bot <= mem_addr_bot[5:0];
    end

    function automatic logic [2:0] px_bits(input int v, input int p);
        logic [5:0] val;
        val = v[5:0];
        return {val[4+p], val[2+p], val[p]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        pause   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Starts on a FETCH cycle, ends on the following FETCH cycle.
    task automatic shift_row(input int fr, input int row, input int pl, output int period);
        int base;
        int low;
        logic [2:0] et, eb;
        logic done;
        base = fr * 16 + row * 4;
        period = 1;
        et = 3'b000;
        eb = 3'b000;
        checks++;
        if (mem_addr_top !== 16'(base) || mem_addr_bot !== 16'(base + 8)) begin
            failures++;
            $display("FAIL fetch_addr: top=%0d bot=%0d required %0d/%0d", mem_addr_top, mem_addr_bot, base, base + 8);
        end
        checks++;
        if ({oe, lat, clk_out} !== 3'b100) begin
            failures++;
            $display("FAIL fetch_ctl: oe,lat,clk_out=%b required 100", {oe, lat, clk_out});
        end
        for (int c = 0; c < 4; c++) begin
            et = px_bits(base + c, pl);
            eb = px_bits(base + 8 + c, pl);
            step(); period++;
            checks++;
            if ({clk_out, r1, g1, b1, r2, g2, b2} !== {1'b0, et, eb}) begin
                failures++;
                $display("FAIL shift_ph0 col%0d: clk,rgb1,rgb2=%b required %b", c, {clk_out, r1, g1, b1, r2, g2, b2}, {1'b0, et, eb});
            end
            if (c < 3) begin
                checks++;
                if (mem_addr_top !== 16'(base + c + 1)) begin
                    failures++;
                    $display("FAIL next_addr col%0d: top=%0d required %0d", c, mem_addr_top, base + c + 1);
                end
            end
            step(); period++;
            checks++;
            if ({clk_out, r1, g1, b1, r2, g2, b2} !== {1'b1, et, eb}) begin
                failures++;
                $display("FAIL shift_ph1 col%0d: clk,rgb1,rgb2=%b required %b", c, {clk_out, r1, g1, b1, r2, g2, b2}, {1'b1, et, eb});
            end
        end
        step(); period++;
        checks++;
        if ({lat, oe, clk_out} !== 3'b110 || row_addr !== 1'(row) || {r1, g1, b1, r2, g2, b2} !== {et, eb}) begin
            failures++;
            $display("FAIL latch: lat,oe,clk=%b row_addr=%0d rgb=%b required 110 %0d %b", {lat, oe, clk_out}, row_addr, {r1, g1, b1, r2, g2, b2}, row, {et, eb});
        end
        low = 0;
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            step();
            if (oe === 1'b1) begin
                done = 1'b1;
            end else begin
                period++;
                low++;
                if (lat !== 1'b0 || clk_out !== 1'b0) begin
                    checks++;
                    failures++;
                    $display("FAIL show_ctl: lat=%b clk_out=%b required 0 0", lat, clk_out);
                end
            end
        end
        checks++;
        if (!done || low != (3 << pl)) begin
            failures++;
            $display("FAIL show_len plane%0d: oe low %0d clks required %0d", pl, low, 3 << pl);
        end
    endtask

    task automatic wait_tick(output int cyc);
        logic seen;
        seen = 1'b0;
        cyc = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            step();
            cyc++;
            if (frame_tick === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL tick_timeout: no frame_tick in %0d clks required one", cyc);
        end
    endtask

    task automatic check_frame(input string name, input int exp);
        checks++;
        if (frame_idx !== 2'(exp)) begin
            failures++;
            $display("FAIL %s: frame_idx=%0d required %0d", name, frame_idx, exp);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({oe, lat, clk_out, r1, g1, b1, r2, g2, b2, frame_tick} !== 10'b1000000000 ||
            row_addr !== 1'b0 || frame_idx !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: oe..tick=%b row=%0d frame=%0d required 1000000000 0 0",
                     {oe, lat, clk_out, r1, g1, b1, r2, g2, b2, frame_tick}, row_addr, frame_idx);
        end
    endtask

    task automatic test_refresh();
        int p0, p1, p2, p3;
        shift_row(0, 0, 0, p0);
        checks++;
        if (frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL tick_early: frame_tick=%b required 0", frame_tick);
        end
        shift_row(0, 0, 1, p1);
        shift_row(0, 1, 0, p2);
        shift_row(0, 1, 1, p3);
        checks++;
        if (p0 != 13 || p1 != 16) begin
            failures++;
            $display("FAIL plane_period: %0d/%0d required 13/16", p0, p1);
        end
        checks++;
        if (p0 + p1 + p2 + p3 != 58) begin
            failures++;
            $display("FAIL refresh_len: %0d required 58", p0 + p1 + p2 + p3);
        end
        checks++;
        if (frame_tick !== 1'b1) begin
            failures++;
            $display("FAIL tick_end: frame_tick=%b required 1", frame_tick);
        end
        check_frame("frame_after_tick1", 0);
    endtask

    task automatic test_frames();
        int cyc;
        wait_tick(cyc);
        checks++;
        if (cyc != 58) begin
            failures++;
            $display("FAIL tick_interval: %0d clks required 58", cyc);
        end
        check_frame("frame_after_tick2", 1);
        checks++;
        if (mem_addr_top !== 16'd16 || mem_addr_bot !== 16'd24) begin
            failures++;
            $display("FAIL frame1_addr: top=%0d bot=%0d required 16/24", mem_addr_top, mem_addr_bot);
        end
        step();
        checks++;
        if (frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL tick_width: frame_tick=%b required 0", frame_tick);
        end
        wait_tick(cyc); check_frame("frame_after_tick3", 1);
        wait_tick(cyc); check_frame("frame_after_tick4", 2);
        wait_tick(cyc); check_frame("frame_after_tick5", 2);
        wait_tick(cyc); check_frame("frame_after_tick6", 0);
    endtask

    task automatic test_pause();
        int cyc;
        apply_reset();
        wait_tick(cyc); check_frame("p_tick1", 0);
        wait_tick(cyc); check_frame("p_tick2", 1);
        pause = 1'b1;
        wait_tick(cyc); check_frame("p_tick3", 1);
        wait_tick(cyc); check_frame("p_tick4", 1);
        wait_tick(cyc); check_frame("p_tick5", 1);
        pause = 1'b0;
        wait_tick(cyc); check_frame("p_tick6", 1);
        wait_tick(cyc); check_frame("p_tick7", 2);
        repeat (10) step();
        pause = 1'b1;
        repeat (20) step();
        pause = 1'b0;
        wait_tick(cyc); check_frame("p_tick8", 2);
        wait_tick(cyc); check_frame("p_tick9", 0);
        wait_tick(cyc); check_frame("p_tick10", 0);
        wait_tick(cyc); check_frame("p_tick11", 1);
    endtask

    task automatic test_reset_mid_show();
        logic found;
        int n;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            step();
            if (oe === 1'b0) found = 1'b1;
        end
        checks++;
        if (!found || frame_idx !== 2'd1) begin
            failures++;
            $display("FAIL show_reach: oe=%b frame=%0d required 0 1", oe, frame_idx);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({oe, lat, clk_out, frame_tick} !== 4'b1000 || frame_idx !== 2'd0) begin
            failures++;
            $display("FAIL async_reset: oe,lat,clk,tick=%b frame=%0d required 1000 0", {oe, lat, clk_out, frame_tick}, frame_idx);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        checks++;
        if (mem_addr_top !== 16'd0 || mem_addr_bot !== 16'd8) begin
            failures++;
            $display("FAIL restart_addr: top=%0d bot=%0d required 0/8", mem_addr_top, mem_addr_bot);
        end
        found = 1'b0;
        n = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            n++;
            if (lat === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found || n != 9 || row_addr !== 1'b0) begin
            failures++;
            $display("FAIL restart_latch: lat after %0d clks row=%0d required 9 0", n, row_addr);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        pause    = 1'b0;
        test_reset();
        test_refresh();
        test_frames();
        test_pause();
        test_reset_mid_show();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
